chorus_lfo: RTL

- Triangle-wave LFO that drives the signed extra-delay control input of the chorus delay line.
- Advances once per audio sample strobe, the same strobe that marks a new input packet to the delay buffer.
- Outputs a signed delay offset in samples, swinging about zero with programmable rate and depth.
- Sits in the DSP clock domain between the control registers and the delay buffer.

---
 rtl/chorus_lfo_pkg.sv | 20 ++
 rtl/chorus_lfo_if.sv | 30 +++
 rtl/chorus_lfo_tri.sv | 25 ++
 rtl/chorus_lfo.sv | 127 ++++++++++++
 4 files changed

// File: rtl/chorus_lfo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : chorus_pkg
//  Description : Shared constants and types for the chorus LFO and the
//                delay line it modulates.
//  Revision    : 1.0 - initial release
// ============================================================================
package chorus_pkg;

    localparam int DELAY_WIDTH = 14;
    localparam int PHASE_WIDTH = 24;
    localparam int TRI_WIDTH   = 16;
    localparam int TRI_OFFSET  = 16384;
    localparam int DEPTH_SHIFT = 14;

    typedef logic signed [DELAY_WIDTH-1:0] delay_t;
    typedef logic signed [TRI_WIDTH-1:0]   tri_t;

endpackage
`default_nettype wire

// File: rtl/chorus_lfo_if.sv
`default_nettype none
// ============================================================================
//  Module      : chorus_lfo_if
//  Description : Control/strobe inputs and delay-offset outputs of the chorus
//                LFO. The master drives the strobe and control values; the
//                slave (the LFO) returns the delay offset.
//  Revision    : 1.0 - initial release
// ============================================================================
interface chorus_lfo_if #(
    parameter int PHASE_WIDTH = 24,
    parameter int DELAY_WIDTH = 14
);
    logic                   sample_strobe_i;
    logic                   sync_i;
    logic [PHASE_WIDTH-1:0] rate_i;
    logic [DELAY_WIDTH-1:0] depth_i;
    logic [DELAY_WIDTH-1:0] extra_delay_o;
    logic                   extra_delay_valid_o;

    modport master (
        output sample_strobe_i, sync_i, rate_i, depth_i,
        input  extra_delay_o, extra_delay_valid_o
    );

    modport slave (
        input  sample_strobe_i, sync_i, rate_i, depth_i,
        output extra_delay_o, extra_delay_valid_o
    );
endinterface
`default_nettype wire

// File: rtl/chorus_lfo_tri.sv
`default_nettype none
// ============================================================================
//  Module      : chorus_lfo_tri
//  Description : Folds the top 16 phase bits into a signed triangle sample in
//                the range -16384..16383. Purely combinational.
//  Revision    : 1.0 - initial release
// ============================================================================
module chorus_lfo_tri
    import chorus_pkg::*;
(
    input  wire logic [15:0] q,
    output tri_t             triVal
);

    logic [14:0] w_folded;

    // Mirror the second half of the period so the ramp runs back down.
    always_comb begin
        w_folded = q[15] ? ~q[14:0] : q[14:0];
    end

    assign triVal = tri_t'({1'b0, w_folded}) - tri_t'(TRI_OFFSET);

endmodule
`default_nettype wire

// File: rtl/chorus_lfo.sv
`default_nettype none
// ============================================================================
//  Module      : chorus_lfo
//  Description : Triangle LFO producing a signed extra-delay offset for the
//                chorus delay line. Two-stage pipeline advanced by the audio
//                sample strobe. Optional macro CHORUS_LFO_DEPTH_SLEW_EN makes
//                the applied depth ramp by one sample per strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module chorus_lfo #(
    parameter int PHASE_WIDTH = 24,
    parameter int DELAY_WIDTH = 14,
    parameter int MAX_DEPTH   = 800
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    chorus_lfo_if.slave    lfo
);
    import chorus_pkg::*;

    localparam logic [DELAY_WIDTH-1:0] c_maxDepth = DELAY_WIDTH'(MAX_DEPTH);
    localparam int                     c_prodTop  = TRI_WIDTH + DELAY_WIDTH;

    generate
        if (MAX_DEPTH < 0 || MAX_DEPTH > (2 ** (DELAY_WIDTH - 1)) - 1) begin : g_badMaxDepth
            $fatal(1, "chorus_lfo: MAX_DEPTH out of range for DELAY_WIDTH");
        end
        if (PHASE_WIDTH < 16) begin : g_badPhaseWidth
            $fatal(1, "chorus_lfo: PHASE_WIDTH must be at least 16");
        end
    endgenerate

    logic [PHASE_WIDTH-1:0]   r_phase;
    tri_t                     r_tri;
    logic [DELAY_WIDTH-1:0]   r_depth;
    logic                     r_validS1;
    logic [DELAY_WIDTH-1:0]   r_extraDelay;
    logic                     r_validOut;

    logic [15:0]              w_q;
    tri_t                     w_tri;
    logic [DELAY_WIDTH-1:0]   w_depthClamp;
    logic [DELAY_WIDTH-1:0]   w_depthStage;
    logic signed [c_prodTop:0] w_prod;
    logic                     w_unused_prodBits;

    assign w_q = r_phase[PHASE_WIDTH-1 -: 16];

    chorus_lfo_tri u_tri (
        .q      (w_q),
        .triVal (w_tri)
    );

    // Limit the requested depth so the output never exceeds the buffer headroom.
    always_comb begin
        w_depthClamp = (lfo.depth_i > c_maxDepth) ? c_maxDepth : lfo.depth_i;
    end

`ifdef CHORUS_LFO_DEPTH_SLEW_EN
    logic [DELAY_WIDTH-1:0] r_depthEff;

    // Next applied depth: one step toward the clamped target.
    always_comb begin
        w_depthStage = r_depthEff;
        if (r_depthEff < w_depthClamp) begin
            w_depthStage = r_depthEff + 1'b1;
        end else if (r_depthEff > w_depthClamp) begin
            w_depthStage = r_depthEff - 1'b1;
        end
    end

    // Applied depth starts at zero so the chorus fades in after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_depthEff <= '0;
        end else if (lfo.sample_strobe_i) begin
            r_depthEff <= w_depthStage;
        end
    end
`else
    assign w_depthStage = w_depthClamp;
`endif

    // Stage 1: capture triangle and depth, advance or restart the phase.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_phase   <= '0;
            r_tri     <= '0;
            r_depth   <= '0;
            r_validS1 <= 1'b0;
        end else begin
            r_validS1 <= lfo.sample_strobe_i;
            if (lfo.sample_strobe_i) begin
                r_tri   <= w_tri;
                r_depth <= w_depthStage;
            end
            // Sync wins over the increment: the phase restarts at exactly 0.
            if (lfo.sync_i) begin
                r_phase <= '0;
            end else if (lfo.sample_strobe_i) begin
                r_phase <= r_phase + lfo.rate_i;
            end
        end
    end

    // Scale by depth; the >>> 14 floors, keeping the result in -depth..depth-1.
    assign w_prod = r_tri * $signed({1'b0, r_depth});
    assign w_unused_prodBits = ^{w_prod[DEPTH_SHIFT-1:0], w_prod[c_prodTop:DEPTH_SHIFT+DELAY_WIDTH]};

    // Stage 2: register the scaled offset and its valid pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_extraDelay <= '0;
            r_validOut   <= 1'b0;
        end else begin
            r_validOut <= r_validS1;
            if (r_validS1) begin
                r_extraDelay <= w_prod[DEPTH_SHIFT +: DELAY_WIDTH];
            end
        end
    end

    assign lfo.extra_delay_o       = r_extraDelay;
    assign lfo.extra_delay_valid_o = r_validOut;

endmodule
`default_nettype wire
